// File: rtl/keypad_scanner_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scanner_pkg : shared states, idle row pattern and key map
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package keypad_scanner_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      PRESSED  = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Indexed by {row, col}; element 0 is row 0 / column 0.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hE, 4'hF, 4'h0,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [1:0] first_low_row(input logic [3:0] i_rs);
      logic [1:0] w_idx;
      casez (i_rs)
         4'b???0: w_idx = 2'd0;
         4'b??01: w_idx = 2'd1;
         4'b?011: w_idx = 2'd2;
         default: w_idx = 2'd3;
      endcase
      return w_idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if : keypad matrix lines and decoded key outputs
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface keypad_scanner_if;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  rows,
      output cols,
      output key,
      output key_valid,
      output key_held
   );

   modport slave (
      output rows,
      input  cols,
      input  key,
      input  key_valid,
      input  key_held
   );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner_scan_tick_gen.sv
// -----------------------------------------------------------------------------
// keypad_scanner_scan_tick_gen : divider giving a one-CLK scan enable pulse
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module keypad_scanner_scan_tick_gen #(
   parameter int TICK_DIV = 5000
) (
   input  logic CLK,
   input  logic RESET,
   output logic o_tick
);

   localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

   logic [c_CW-1:0] r_cnt;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

   assign o_tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner : column-multiplexed 4x4 keypad reader with press/release debounce
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int TICK_DIV       = 5000,
   parameter int DEBOUNCE_TICKS = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   keypad_scanner_if.master  kp
);

   localparam int c_CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);

   logic              w_tick;
   logic [3:0]        r_rows_meta;
   logic [3:0]        r_rs;
   state_t            r_state;
   logic [1:0]        r_col;
   logic [1:0]        r_row;
   logic [c_CNT_W-1:0] r_cnt;
   logic [3:0]        r_key;
   logic              r_valid;
   logic              r_held;
   logic              w_idle;
   logic [1:0]        w_row;

   keypad_scanner_scan_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .CLK    (CLK),
      .RESET  (RESET),
      .o_tick (w_tick)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rows_meta <= ROW_IDLE;
         r_rs        <= ROW_IDLE;
      end else begin
         r_rows_meta <= kp.rows;
         r_rs        <= r_rows_meta;
      end
   end

   assign w_idle = (r_rs == ROW_IDLE);
   assign w_row  = first_low_row(r_rs);

   // Column index only moves in SCAN or after a debounced release.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= SCAN;
         r_col   <= 2'd0;
         r_row   <= 2'd0;
         r_cnt   <= '0;
         r_key   <= 4'h0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_tick) begin
            case (r_state)
               SCAN: begin
                  if (w_idle) begin
                     r_col <= r_col + 2'd1;
                  end else begin
                     r_row   <= w_row;
                     r_cnt   <= '0;
                     r_state <= PRESS_DB;
                  end
               end
               PRESS_DB: begin
                  if (!w_idle && (w_row == r_row)) begin
                     if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_key   <= KEY_MAP[{r_row, r_col}];
                        r_valid <= 1'b1;
                        r_held  <= 1'b1;
                        r_state <= PRESSED;
                     end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                     end
                  end else begin
                     r_state <= SCAN;
                  end
               end
               PRESSED: begin
                  if (w_idle) begin
                     r_cnt   <= '0;
                     r_state <= REL_DB;
                  end
               end
               REL_DB: begin
                  if (!w_idle) begin
                     r_cnt   <= '0;
                     r_state <= PRESSED;
                  end else if (r_cnt == c_CNT_LAST) begin
                     r_cnt   <= '0;
                     r_held  <= 1'b0;
                     r_col   <= r_col + 2'd1;
                     r_state <= SCAN;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_W'(1);
                  end
               end
               default: r_state <= SCAN;
            endcase
         end
      end
   end

   assign kp.cols      = ~(4'b0001 << r_col);
   assign kp.key       = r_key;
   assign kp.key_valid = r_valid;
   assign kp.key_held  = r_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner : directed checks of scan, debounce, key map and reset
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scanner;

   localparam int c_TICK = 4;
   localparam int c_DEB  = 8;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [15:0] r_pressed = 16'h0000;
   int          tests = 0;
   int          fails = 0;
   int          pulses = 0;
   int          p0 = 0;
   logic [3:0]  r_cols_prev;

   keypad_scanner_if kp_if ();

   keypad_scanner #(
      .TICK_DIV       (c_TICK),
      .DEBOUNCE_TICKS (c_DEB)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .kp    (kp_if)
   );

   always #5 CLK = ~CLK;

   // Keypad model: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      kp_if.rows = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r_pressed[r*4+c] && !kp_if.cols[c]) kp_if.rows[r] = 1'b0;
         end
      end
   end

   always @(negedge CLK) begin
      if (kp_if.key_valid === 1'b1) pulses = pulses + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_held(input string tag, input logic lvl, input int max_cyc);
      bit ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge CLK);
         if (kp_if.key_held === lvl) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, {7'd0, ok}, 8'd1);
   endtask

   task automatic wait_cols(input string tag, input logic [3:0] val, input int max_cyc);
      bit ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge CLK);
         if (kp_if.cols === val) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, {7'd0, ok}, 8'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cols"},  {4'd0, kp_if.cols}, 8'h0E);
      check({tag, "_key"},   {4'd0, kp_if.key},  8'h00);
      check({tag, "_valid"}, {7'd0, kp_if.key_valid}, 8'h00);
      check({tag, "_held"},  {7'd0, kp_if.key_held},  8'h00);
   endtask

   initial begin
      #1;
      check_reset_outputs("rst0");
      cycles(3);
      RESET = 1'b0;
      cycles(6);

      // Asynchronous reset mid-cycle, then the column walk.
      #2 RESET = 1'b1;
      #1 check_reset_outputs("rst_async");
      @(negedge CLK);
      RESET = 1'b0;
      cycles(3);
      check("scan_c0_hold", {4'd0, kp_if.cols}, 8'h0E);
      cycles(1);
      check("scan_c1", {4'd0, kp_if.cols}, 8'h0D);
      cycles(c_TICK);
      check("scan_c2", {4'd0, kp_if.cols}, 8'h0B);
      cycles(c_TICK);
      check("scan_c3", {4'd0, kp_if.cols}, 8'h07);
      cycles(c_TICK);
      check("scan_wrap", {4'd0, kp_if.cols}, 8'h0E);

      // Clean press of '5' (row 1, column 1).
      p0 = pulses;
      r_pressed[5] = 1'b1;
      wait_held("k5_accept", 1'b1, 30 * c_TICK);
      cycles(20 * c_TICK);
      check("k5_pulses", 8'(pulses - p0), 8'd1);
      check("k5_key", {4'd0, kp_if.key}, 8'h05);
      check("k5_held", {7'd0, kp_if.key_held}, 8'h01);
      r_pressed[5] = 1'b0;
      cycles(c_DEB * c_TICK);
      check("k5_held_reldb", {7'd0, kp_if.key_held}, 8'h01);
      wait_held("k5_release", 1'b0, 3 * c_TICK);
      check("k5_next_col", {4'd0, kp_if.cols}, 8'h0B);

      // Bouncing 'C' (row 2, column 3) never settles long enough.
      p0 = pulses;
      repeat (5) begin
         r_pressed[11] = 1'b1;
         cycles(2 * c_TICK);
         r_pressed[11] = 1'b0;
         cycles(c_TICK);
      end
      cycles(4 * c_TICK);
      check("bounce_pulses", 8'(pulses - p0), 8'd0);
      check("bounce_held", {7'd0, kp_if.key_held}, 8'h00);
      r_cols_prev = kp_if.cols;
      cycles(c_TICK);
      check("bounce_scanning", {7'd0, kp_if.cols !== r_cols_prev}, 8'h01);
      r_pressed[11] = 1'b1;
      wait_held("kC_accept", 1'b1, 20 * c_TICK);
      cycles(2);
      check("kC_key", {4'd0, kp_if.key}, 8'h0C);
      check("kC_pulses", 8'(pulses - p0), 8'd1);
      r_pressed[11] = 1'b0;
      wait_held("kC_release", 1'b0, 12 * c_TICK);

      // Release bounce on '0' (row 3, column 0).
      p0 = pulses;
      r_pressed[12] = 1'b1;
      wait_held("k0_accept", 1'b1, 20 * c_TICK);
      r_pressed[12] = 1'b0;
      cycles(3 * c_TICK);
      check("k0_held_gap", {7'd0, kp_if.key_held}, 8'h01);
      r_pressed[12] = 1'b1;
      cycles(4 * c_TICK);
      check("k0_held_again", {7'd0, kp_if.key_held}, 8'h01);
      check("k0_pulses", 8'(pulses - p0), 8'd1);
      check("k0_key", {4'd0, kp_if.key}, 8'h00);
      r_pressed[12] = 1'b0;
      wait_held("k0_release", 1'b0, 12 * c_TICK);

      // '1' and '7' together in column 0: lowest row wins.
      r_pressed[0] = 1'b1;
      r_pressed[8] = 1'b1;
      wait_held("k17_accept", 1'b1, 20 * c_TICK);
      cycles(2);
      check("k17_key", {4'd0, kp_if.key}, 8'h01);
      r_pressed[0] = 1'b0;
      r_pressed[8] = 1'b0;
      wait_held("k17_release", 1'b0, 12 * c_TICK);

      // Reset during PRESS_DB for '6' (row 1, column 2).
      p0 = pulses;
      r_pressed[6] = 1'b1;
      wait_cols("k6_reach_col", 4'b1011, 6 * c_TICK);
      cycles(3 * c_TICK);
      check("k6_col_frozen", {4'd0, kp_if.cols}, 8'h0B);
      check("k6_not_yet", {7'd0, kp_if.key_held}, 8'h00);
      #2 RESET = 1'b1;
      #1 check_reset_outputs("rst_pressdb");
      @(negedge CLK);
      RESET = 1'b0;
      wait_held("k6_accept", 1'b1, 20 * c_TICK);
      cycles(2);
      check("k6_key", {4'd0, kp_if.key}, 8'h06);
      check("k6_pulses", 8'(pulses - p0), 8'd1);

      // Reset during PRESSED: held key is accepted again with one new pulse.
      cycles(2 * c_TICK);
      #2 RESET = 1'b1;
      #1 check_reset_outputs("rst_pressed");
      @(negedge CLK);
      RESET = 1'b0;
      wait_held("k6_reaccept", 1'b1, 20 * c_TICK);
      cycles(2);
      check("k6_rekey", {4'd0, kp_if.key}, 8'h06);
      check("k6_repulses", 8'(pulses - p0), 8'd2);
      r_pressed[6] = 1'b0;
      wait_held("k6_release", 1'b0, 12 * c_TICK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
